number_game_scoreboard: RTL and testbench

// Downstream of the number-game controller: keeps a ranked high-score table of finished rounds
// and renders it on the six 7-segment digits while the controller sits in its scoreboard state.

---
 rtl/number_game_scoreboard_if.sv | 11 +
 rtl/number_game_scoreboard.sv | 167 ++++++++++++++++
 tb/tb_number_game_scoreboard.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/number_game_scoreboard_if.sv
// Record handshake between the number-game controller and its high-score table.
interface number_game_scoreboard_if;
   logic       rec_valid;
   logic [6:0] rec_score;
   logic [3:0] rec_diff;
   logic       rec_success;
   logic       rec_ready;

   modport master (output rec_valid, rec_score, rec_diff, rec_success, input rec_ready);
   modport slave  (input rec_valid, rec_score, rec_diff, rec_success, output rec_ready);
endinterface

// File: rtl/number_game_scoreboard.sv
// Ranked high-score table: insertion-sorts finished rounds one slot per cycle and
// pages through the ranked entries on six active-low 7-segment digits.
module number_game_scoreboard #(
   parameter int ENTRIES = 4,
   parameter int PAGE_N  = 50000000
) (
   input  logic                     clock,
   input  logic                     resetn,
   input  logic                     i_clear,
   number_game_scoreboard_if.slave  rec,
   input  logic                     i_show,
   output logic [2:0]               o_count,
   output logic [6:0]               o_hex5,
   output logic [6:0]               o_hex4,
   output logic [6:0]               o_hex3,
   output logic [6:0]               o_hex2,
   output logic [6:0]               o_hex1,
   output logic [6:0]               o_hex0
);
   localparam int              TW     = (PAGE_N > 1) ? $clog2(PAGE_N) : 1;
   localparam logic [TW-1:0]   TMAX   = TW'(PAGE_N - 1);
   localparam logic [2:0]      NENT   = 3'(ENTRIES);
   localparam logic [2:0]      LAST   = 3'(ENTRIES - 1);
   localparam logic [0:0]      S_IDLE = 1'b0;
   localparam logic [0:0]      S_INS  = 1'b1;
   localparam logic [6:0]      BLANK  = 7'b1111111;
   localparam logic [6:0]      DASH   = 7'b0111111;

   // Fields packed in rank priority so an unsigned compare is the ranking.
   typedef struct packed {
      logic       succ;
      logic [6:0] score;
      logic [3:0] diff;
   } rec_t;

   rec_t              r_tab [0:7];
   rec_t              r_rec;
   logic [0:0]        r_state;
   logic [2:0]        r_idx;
   logic [2:0]        r_count;
   logic [2:0]        r_page;
   logic [TW-1:0]     r_timer;
   logic              r_show_d;
   logic [5:0][6:0]   r_hex;

   rec_t              w_in;
   rec_t              w_e;
   logic [2:0]        w_im1;
   logic [2:0]        w_pg;
   logic [6:0]        w_sc;
   logic              w_beats_prev;
   logic              w_place;
   logic              w_discard;
   logic              w_cnt_chg;
   logic              w_show_rise;
   logic [5:0][6:0]   w_hex;

   function automatic logic [6:0] seg(input logic [3:0] d);
      case (d)
         4'd0: seg = 7'b1000000;
         4'd1: seg = 7'b1111001;
         4'd2: seg = 7'b0100100;
         4'd3: seg = 7'b0110000;
         4'd4: seg = 7'b0011001;
         4'd5: seg = 7'b0010010;
         4'd6: seg = 7'b0000010;
         4'd7: seg = 7'b1111000;
         4'd8: seg = 7'b0000000;
         4'd9: seg = 7'b0010000;
         default: seg = BLANK;
      endcase
   endfunction

   assign w_in         = '{succ: rec.rec_success, score: rec.rec_score, diff: rec.rec_diff};
   assign w_im1        = r_idx - 3'd1;
   // Slots at or beyond count are invalid and lose to any record.
   assign w_beats_prev = (w_im1 >= r_count) || (r_rec > r_tab[w_im1]);
   assign w_place      = (r_idx == 3'd0) || !w_beats_prev;
   assign w_discard    = (r_count == NENT) && !(w_in > r_tab[LAST]);
   assign w_cnt_chg    = (r_state == S_INS) && w_place && (r_count != NENT);
   assign w_show_rise  = i_show && !r_show_d;
   assign rec.rec_ready = (r_state == S_IDLE);
   assign o_count      = r_count;

   // Insertion FSM: accept a record, then shift worse entries down one slot per cycle.
   always_ff @(posedge clock) begin
      if (!resetn || i_clear) begin
         r_state <= S_IDLE;
         r_count <= '0;
         r_idx   <= '0;
      end else begin
         case (r_state)
            S_IDLE: if (rec.rec_valid) begin
               r_rec <= w_in;
               if (!w_discard) begin
                  r_state <= S_INS;
                  r_idx   <= LAST;
               end
            end
            default: if (w_place) begin
               r_tab[r_idx] <= r_rec;
               if (r_count != NENT) r_count <= r_count + 3'd1;
               r_state <= S_IDLE;
            end else begin
               r_tab[r_idx] <= r_tab[w_im1];
               r_idx        <= w_im1;
            end
         endcase
      end
   end

   // Show edge detector.
   always_ff @(posedge clock) begin
      if (!resetn) r_show_d <= 1'b0;
      else         r_show_d <= i_show;
   end

   // Page timer: restart from the top entry on show rising or a new entry; frozen while hidden.
   always_ff @(posedge clock) begin
      if (!resetn || i_clear || w_show_rise || w_cnt_chg) begin
         r_page  <= '0;
         r_timer <= '0;
      end else if (i_show && r_count != 3'd0) begin
         if (r_timer == TMAX) begin
            r_timer <= '0;
            r_page  <= (r_page == r_count - 3'd1) ? 3'd0 : r_page + 3'd1;
         end else begin
            r_timer <= r_timer + 1'b1;
         end
      end
   end

   // Use page 0 on the show edge itself so a stale page never flashes up.
   assign w_pg = w_show_rise ? 3'd0 : r_page;
   assign w_e  = r_tab[w_pg];
   assign w_sc = (w_e.score > 7'd99) ? 7'd99 : w_e.score;

   // Digit decode for the current page.
   always_comb begin
      w_hex = {6{BLANK}};
      if (i_show) begin
         if (r_count == 3'd0) begin
            w_hex = {6{DASH}};
         end else begin
            w_hex[5] = seg(4'(w_pg + 3'd1));
            w_hex[4] = w_e.succ ? 7'b0010010 : 7'b0001110;
            w_hex[3] = seg(4'(w_e.diff / 4'd10));
            w_hex[2] = seg(4'(w_e.diff % 4'd10));
            w_hex[1] = seg(4'(w_sc / 7'd10));
            w_hex[0] = seg(4'(w_sc % 7'd10));
         end
      end
   end

   // Registered display outputs.
   always_ff @(posedge clock) begin
      if (!resetn) r_hex <= {6{BLANK}};
      else         r_hex <= w_hex;
   end

   assign o_hex5 = r_hex[5];
   assign o_hex4 = r_hex[4];
   assign o_hex3 = r_hex[3];
   assign o_hex2 = r_hex[2];
   assign o_hex1 = r_hex[1];
   assign o_hex0 = r_hex[0];
endmodule

// File: tb/tb_number_game_scoreboard.sv
// Scoreboard bench: driver pushes expected counts / display frames, monitor pops on DUT events.
module tb_number_game_scoreboard;
   localparam int ENT = 4;
   localparam int PN  = 4;

   logic       clock  = 1'b0;
   logic       resetn = 1'b0;
   logic       clear  = 1'b0;
   logic       show   = 1'b0;
   logic [2:0] count;
   logic [6:0] h5, h4, h3, h2, h1, h0;

   number_game_scoreboard_if ifc ();

   number_game_scoreboard #(.ENTRIES(ENT), .PAGE_N(PN)) u_dut (
      .clock   (clock),
      .resetn  (resetn),
      .i_clear (clear),
      .rec     (ifc.slave),
      .i_show  (show),
      .o_count (count),
      .o_hex5  (h5),
      .o_hex4  (h4),
      .o_hex3  (h3),
      .o_hex2  (h2),
      .o_hex1  (h1),
      .o_hex0  (h0)
   );

   always #5 clock = ~clock;

   typedef struct { int score; int diff; bit succ; } mrec_t;

   mrec_t       tab[$];
   int          q_cnt[$];
   logic [41:0] q_disp[$];
   int          n_cmp = 0;
   int          n_bad = 0;

   localparam logic [41:0] W_BLANK = {6{7'b1111111}};
   localparam logic [41:0] W_DASH  = {6{7'b0111111}};

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   function automatic bit beats(mrec_t a, mrec_t b);
      if (a.succ != b.succ)   return a.succ;
      if (a.score != b.score) return a.score > b.score;
      return a.diff > b.diff;
   endfunction

   function automatic logic [6:0] seg(int d);
      case (d)
         0: return 7'b1000000;  1: return 7'b1111001;  2: return 7'b0100100;
         3: return 7'b0110000;  4: return 7'b0011001;  5: return 7'b0010010;
         6: return 7'b0000010;  7: return 7'b1111000;  8: return 7'b0000000;
         9: return 7'b0010000;  default: return 7'b1111111;
      endcase
   endfunction

   function automatic logic [41:0] frame(mrec_t e, int rank);
      int s = (e.score > 99) ? 99 : e.score;
      return {seg(rank), e.succ ? 7'b0010010 : 7'b0001110,
              seg(e.diff / 10), seg(e.diff % 10), seg(s / 10), seg(s % 10)};
   endfunction

   // Reference: stable sorted insert into a list capped at ENT entries.
   function automatic bit model_insert(mrec_t r);
      int pos = tab.size();
      for (int k = 0; k < tab.size(); k++)
         if (beats(r, tab[k])) begin pos = k; break; end
      if (pos >= ENT) return 1'b0;
      tab.insert(pos, r);
      if (tab.size() > ENT) void'(tab.pop_back());
      return 1'b1;
   endfunction

   task automatic wait_ready(input string nm);
      int t = 0;
      while (!ifc.rec_ready && t < 40) begin @(posedge clock); #1; t++; end
      if (!ifc.rec_ready) begin
         n_cmp++; n_bad++;
         $display("FAIL %s: rec_ready still 0 after %0d cycles, expected 1", nm, t);
      end
   endtask

   task automatic send(input int sc, input int df, input bit su, input bit junk, input bit clr);
      mrec_t r;
      bit    acc;
      wait_ready("ready_before_send");
      r.score = sc; r.diff = df; r.succ = su;
      ifc.rec_score = 7'(sc); ifc.rec_diff = 4'(df); ifc.rec_success = su;
      ifc.rec_valid = 1'b1;
      acc = model_insert(r);
      if (acc) q_cnt.push_back(clr ? 0 : tab.size());
      @(posedge clock); #1;
      ifc.rec_valid = 1'b0;
      if (clr) begin
         tab.delete();
         clear = 1'b1;
         @(posedge clock); #1;
         clear = 1'b0;
      end else if (junk && acc) begin
         ifc.rec_score = 7'($urandom); ifc.rec_diff = 4'($urandom_range(1, 10));
         ifc.rec_success = 1'($urandom); ifc.rec_valid = 1'b1;
         @(posedge clock); #1;
         ifc.rec_valid = 1'b0;
      end
      wait_ready("ready_after_send");
   endtask

   // Expected frames: each page in rank order, back to the top, then blank when hidden.
   task automatic show_table();
      int c = tab.size();
      if (c == 0) q_disp.push_back(W_DASH);
      else begin
         for (int k = 0; k < c; k++) q_disp.push_back(frame(tab[k], k + 1));
         if (c > 1) q_disp.push_back(frame(tab[0], 1));
      end
      q_disp.push_back(W_BLANK);
      show = 1'b1;
      repeat (4 * c + 3) @(posedge clock);
      #1 show = 1'b0;
      repeat (3) @(posedge clock);
      #1;
   endtask

   // Monitor: compare on every display change and every end of an insertion.
   logic [41:0] prev_hex = W_BLANK;
   logic [41:0] cur_hex;
   logic        prev_rdy = 1'b1;
   int          busy     = 0;
   always @(negedge clock) begin
      if (resetn) begin
         cur_hex = {h5, h4, h3, h2, h1, h0};
         if (cur_hex !== prev_hex) begin
            if (q_disp.size() == 0) begin
               n_cmp++; n_bad++;
               $display("FAIL disp_unexpected: got %0h expected no change", cur_hex);
            end else chk("disp", cur_hex, q_disp.pop_front());
            prev_hex = cur_hex;
         end
         if (!ifc.rec_ready) busy++;
         if (ifc.rec_ready && !prev_rdy) begin
            n_cmp++;
            if (busy > ENT) begin
               n_bad++;
               $display("FAIL insert_latency: got %0d cycles expected <= %0d", busy, ENT);
            end
            if (q_cnt.size() == 0) begin
               n_cmp++; n_bad++;
               $display("FAIL insert_unexpected: got count %0d expected no insertion", count);
            end else chk("count", 64'(count), 64'(q_cnt.pop_front()));
            busy = 0;
         end
         prev_rdy = ifc.rec_ready;
      end
   end

   initial begin
      #3000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      ifc.rec_valid = 1'b0; ifc.rec_score = '0; ifc.rec_diff = '0; ifc.rec_success = 1'b0;
      repeat (3) @(posedge clock);
      #1 resetn = 1'b1;
      chk("rst_count", 64'(count), 64'd0);
      chk("rst_ready", 64'(ifc.rec_ready), 64'd1);
      chk("rst_hex", 64'({h5, h4, h3, h2, h1, h0}), 64'(W_BLANK));
      show_table();

      send(7, 3, 1, 0, 0);
      send(12, 2, 0, 0, 0);
      send(7, 5, 1, 0, 0);
      show_table();
      send(7, 3, 1, 1, 0);     // duplicate, with a pulse during INSERT
      show_table();
      send(1, 1, 0, 0, 0);     // full table, worse than last: discarded
      show_table();
      send(120, 10, 1, 0, 0);  // shown as 99
      show_table();
      send(127, 10, 1, 0, 1);  // clear mid-insertion
      show_table();

      for (int i = 0; i < 48; i++) begin
         if ($urandom_range(0, 11) == 0) begin
            clear = 1'b1;
            tab.delete();
            @(posedge clock); #1 clear = 1'b0;
         end else begin
            send($urandom_range(0, 1) ? $urandom_range(0, 12) : $urandom_range(0, 127),
                 $urandom_range(1, 10), 1'($urandom), 1'($urandom), 1'b0);
         end
         if (i % 8 == 7) show_table();
      end
      show_table();

      repeat (5) @(posedge clock);
      #1;
      chk("q_cnt_left", 64'(q_cnt.size()), 64'd0);
      chk("q_disp_left", 64'(q_disp.size()), 64'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
